multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared-ALU, single-memory multicycle RISC-V datapath for the same ISA subset the pipelined decoder handles: R, I, LW, SW, B (beq/bne/blt/bge), JAL, JALR, LUI.
- Drives every mux select and write strobe of the datapath: PC, IR, OldPC, ALUOut, register file and memory.
- Waits on a memory-ready handshake for fetch, load and store.
- Resolves branches internally from the ALU flags.

Parameters:
- STATE_W, 4, width of the state register (must hold 14 encodings).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opc  in  7  opcode from IR
- func3  in  3  func3 from IR
- zero  in  1  ALU result == 0
- neg  in  1  ALU result sign bit
- mem_ready  in  1  memory completes the access this cycle
- PCWrite  out  1  PC <= Result
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR <= rdata and OldPC <= PC
- RegWrite  out  1  register-file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 Imm
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 Imm, 10 const 4
- ALU_opc  out  2  00 add, 01 sub, 10 R-decode, 11 I-decode (same coding as the pipelined decoder)
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- retire  out  1  one-cycle pulse in the final cycle of each instruction

Behaviour:
- Outputs are a pure function of state, plus func3/flags in BRANCH and mem_ready in the memory states.
- Any output not listed for a state is 0. ALUOut latches ALUResult every cycle; this lives in the datapath.
- rst high:
  - next state FETCH.
  - All strobes (PCWrite, MemWrite, IRWrite, RegWrite, retire) are forced 0 in that cycle, even mid-instruction.
  - The aborted instruction leaves no architectural side effect.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ImmSrc=010; computes branch/JAL target into ALUOut.
  - ImmSrc=011 when opc is J-type.
  - Next state by opc: R→EX_R, I→EX_I, LW/SW→MEM_ADR, B→BRANCH, JAL→JAL, JALR→JALR, LUI→LUI, other→see Optional Feature.
- EX_R: A=10, B=00, ALU_opc=10 → ALU_WB.
- EX_I: A=10, B=01, ImmSrc=000, ALU_opc=11 → ALU_WB.
- ALU_WB: ResultSrc=00, RegWrite=1, retire=1 → FETCH.
- MEM_ADR: A=10, B=01, ImmSrc=000 (LW) or 001 (SW) → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: AdrSrc=1. Hold while !mem_ready; then → MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1, retire=1 → FETCH.
- MEM_WR:
  - AdrSrc=1, MemWrite=1 for every cycle until mem_ready.
  - retire=mem_ready; then → FETCH.
- BRANCH:
  - A=10, B=00, ALU_opc=01, ResultSrc=00, retire=1 → FETCH.
  - PCWrite=taken, where beq: zero; bne: !zero; blt: neg; bge: !neg; other func3: 0.
- JAL: ResultSrc=00 (PC<=target), PCWrite=1, A=01, B=10 (OldPC+4 into ALUOut) → ALU_WB.
- JALR: A=10, B=01, ImmSrc=000, ResultSrc=10, PCWrite=1 → LINK.
- LINK: A=01, B=10 → ALU_WB.
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1, retire=1 → FETCH.
- Latencies (mem_ready always 1):
  - R/I/SW/JAL: 4 cycles; LW: 5; JALR: 5; B: 3; LUI: 3.
  - Each wait cycle adds 1.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE → HALT state. HALT asserts an extra output, illegal=1, and all strobes 0; only rst leaves HALT.
- Undefined: an unknown opcode → FETCH with retire=1 (executes as a NOP). There is no illegal port and no HALT state.

Decomposition:
- Package holds:
  - state encodings: FETCH, DECODE, EX_R, EX_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, LINK, LUI, HALT;
  - opcode constants shared with the pipelined decoder;
  - ResultSrc/ALUSrc/ImmSrc/ALU_opc codes.
- One sub-module, branch_resolver: combinational func3/zero/neg → taken.

Test Plan:
- rst held 2 cycles, mem_ready=1, R-type opc 0110011 → state sequence FETCH, DECODE, EX_R, ALU_WB; RegWrite=1 and retire=1 only in cycle 4.
- LW (0000011) with mem_ready low for 3 cycles in MEM_RD → AdrSrc=1 held 4 cycles; RegWrite in MEM_WB; total 8 cycles.
- beq with zero=1 → PCWrite=1 in BRANCH. bne with zero=1 → PCWrite=0. blt with neg=1 → PCWrite=1. func3=010 → PCWrite=0.
- JALR → PCWrite with ResultSrc=10 in cycle 3; LINK sets A=01, B=10; RegWrite in cycle 5.
- SW, rst asserted during MEM_WR with mem_ready=0 → MemWrite=0 in the rst cycle; FETCH the next cycle; no retire.
- opc 1111111 → HALT with illegal=1 held until rst (ILLEGAL_TRAP_EN); otherwise retire pulse and back to FETCH after 2 cycles.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
//   Shared definitions for the multicycle RISC-V controller:
//     - FSM state encodings (15 states, fits a 4-bit register)
//     - opcode constants shared with the pipelined decoder
//     - mux-select / ALU-operation / immediate-format codes
//     - a packed bundle of every datapath control signal
//   Optional feature macro used by the importing files: ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

    localparam int CTRL_STATE_W = 4;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EX_R    = 4'd2,
        ST_EX_I    = 4'd3,
        ST_ALU_WB  = 4'd4,
        ST_MEM_ADR = 4'd5,
        ST_MEM_RD  = 4'd6,
        ST_MEM_WB  = 4'd7,
        ST_MEM_WR  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JAL     = 4'd10,
        ST_JALR    = 4'd11,
        ST_LINK    = 4'd12,
        ST_LUI     = 4'd13,
        ST_HALT    = 4'd14
    } state_t;

    // Opcodes (identical to the pipelined decoder)
    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    // Branch func3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU_opc
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_RDEC = 2'b10;
    localparam logic [1:0] ALU_IDEC = 2'b11;

    // ImmSrc
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Every control output of the controller in one bundle
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_opc;
        logic [2:0] imm_src;
        logic       retire;
    } ctrl_t;

    function automatic logic is_known_opc(input logic [6:0] opc);
        return (opc == OPC_R)  || (opc == OPC_I)   || (opc == OPC_LW)   ||
               (opc == OPC_SW) || (opc == OPC_B)   || (opc == OPC_JAL)  ||
               (opc == OPC_JALR) || (opc == OPC_LUI);
    endfunction

endpackage

// File: rtl/multicycle_controller_branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//   Combinational branch decision from func3 and the ALU flags of rs1 - rs2.
//   Ports:
//     i_func3  in  3  branch func3
//     i_zero   in  1  ALU result == 0
//     i_neg    in  1  ALU result sign bit
//     o_taken  out 1  branch taken (0 for unsupported func3)
// -----------------------------------------------------------------------------
module branch_resolver
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] i_func3,
    input  logic       i_zero,
    input  logic       i_neg,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        unique case (i_func3)
            F3_BEQ:  o_taken = i_zero;
            F3_BNE:  o_taken = ~i_zero;
            F3_BLT:  o_taken = i_neg;
            F3_BGE:  o_taken = ~i_neg;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Moore FSM sequencing the shared-ALU, single-memory multicycle RISC-V
//   datapath (R, I, LW, SW, B, JAL, JALR, LUI).
//   Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in HALT and
//   raise `illegal`; without it they retire as a NOP.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     opc, func3         instruction fields from IR
//     zero, neg          ALU flags
//     mem_ready          memory finishes the current access this cycle
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//     ResultSrc, ALUSrcA, ALUSrcB, ALU_opc, ImmSrc    datapath mux codes
//     retire             pulse in the last cycle of each instruction
//     illegal            (ILLEGAL_TRAP_EN only) HALT indicator
// -----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALU_opc,
    output logic [2:0] ImmSrc,
    output logic       retire
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    if (STATE_W != CTRL_STATE_W) begin : g_bad_state_w
        $error("STATE_W must equal the package state width");
    end

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;
    logic   w_taken;
`ifdef ILLEGAL_TRAP_EN
    logic   w_illegal;
`endif

    branch_resolver u_branch_resolver (
        .i_func3 (func3),
        .i_zero  (zero),
        .i_neg   (neg),
        .o_taken (w_taken)
    );

    // NOTE: state register uses non-blocking assignment so every flop samples
    // the pre-edge value; reset is synchronous, only the state needs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a signal unassigned and no latch can be inferred.
    always_comb begin
        w_ctrl       = '0;
        w_next_state = r_state;
`ifdef ILLEGAL_TRAP_EN
        w_illegal    = 1'b0;
`endif
        unique case (r_state)
            ST_FETCH: begin
                w_ctrl.adr_src    = 1'b0;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.ir_write   = mem_ready;
                w_ctrl.pc_write   = mem_ready;
                w_next_state      = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                // Speculatively computes OldPC + imm (branch / JAL target)
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = (opc == OPC_JAL) ? IMM_J : IMM_B;
                unique case (opc)
                    OPC_R:    w_next_state = ST_EX_R;
                    OPC_I:    w_next_state = ST_EX_I;
                    OPC_LW,
                    OPC_SW:   w_next_state = ST_MEM_ADR;
                    OPC_B:    w_next_state = ST_BRANCH;
                    OPC_JAL:  w_next_state = ST_JAL;
                    OPC_JALR: w_next_state = ST_JALR;
                    OPC_LUI:  w_next_state = ST_LUI;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_next_state = ST_HALT;
`else
                        // Unknown opcode executes as a NOP
                        w_ctrl.retire = 1'b1;
                        w_next_state  = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_EX_R: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_opc   = ALU_RDEC;
                w_next_state     = ST_ALU_WB;
            end
            ST_EX_I: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = IMM_I;
                w_ctrl.alu_opc   = ALU_IDEC;
                w_next_state     = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.retire     = 1'b1;
                w_next_state      = ST_FETCH;
            end
            ST_MEM_ADR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.imm_src   = (opc == OPC_SW) ? IMM_S : IMM_I;
                w_next_state     = (opc == OPC_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                w_ctrl.adr_src = 1'b1;
                w_next_state   = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            end
            ST_MEM_WB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.retire     = 1'b1;
                w_next_state      = ST_FETCH;
            end
            ST_MEM_WR: begin
                // Write strobe held for the whole access, ready cycle included
                w_ctrl.adr_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.retire    = mem_ready;
                w_next_state     = mem_ready ? ST_FETCH : ST_MEM_WR;
            end
            ST_BRANCH: begin
                // ALUOut still holds the target from DECODE; the ALU compares
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.alu_opc    = ALU_SUB;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = w_taken;
                w_ctrl.retire     = 1'b1;
                w_next_state      = ST_FETCH;
            end
            ST_JAL: begin
                // PC <= target in ALUOut while the ALU forms the link address
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_next_state      = ST_ALU_WB;
            end
            ST_JALR: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.pc_write   = 1'b1;
                w_next_state      = ST_LINK;
            end
            ST_LINK: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_next_state     = ST_ALU_WB;
            end
            ST_LUI: begin
                w_ctrl.imm_src    = IMM_U;
                w_ctrl.result_src = RES_IMM;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.retire     = 1'b1;
                w_next_state      = ST_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_HALT: begin
                w_illegal    = 1'b1;
                w_next_state = ST_HALT;
            end
`endif
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Reset kills every strobe in the same cycle so an aborted instruction
    // leaves no architectural trace.
    always_comb begin
        w_out = w_ctrl;
        if (rst) begin
            w_out.pc_write  = 1'b0;
            w_out.mem_write = 1'b0;
            w_out.ir_write  = 1'b0;
            w_out.reg_write = 1'b0;
            w_out.retire    = 1'b0;
        end
    end

    assign PCWrite   = w_out.pc_write;
    assign AdrSrc    = w_out.adr_src;
    assign MemWrite  = w_out.mem_write;
    assign IRWrite   = w_out.ir_write;
    assign RegWrite  = w_out.reg_write;
    assign ResultSrc = w_out.result_src;
    assign ALUSrcA   = w_out.alu_src_a;
    assign ALUSrcB   = w_out.alu_src_b;
    assign ALU_opc   = w_out.alu_opc;
    assign ImmSrc    = w_out.imm_src;
    assign retire    = w_out.retire;
`ifdef ILLEGAL_TRAP_EN
    assign illegal   = w_illegal;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   For each instruction the bench expands the instruction-level rules into
//   the per-cycle list of expected control words (with the mem_ready value to
//   drive in each cycle), then plays it against the DUT, comparing every
//   cycle. Directed instructions pin latencies and branch decisions with
//   literal values; a random loop covers the rest.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    typedef struct packed {
        logic       ill;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [2:0] imm;
        logic       ret;
    } ctl_t;

    localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LW = 7'b0000011,
                           O_SW = 7'b0100011, O_B = 7'b1100011, O_JAL = 7'b1101111,
                           O_JALR = 7'b1100111, O_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opc;
    logic [2:0] func3;
    logic       zero, neg, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_opc;
    logic [2:0] ImmSrc;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opc(opc), .func3(func3), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALU_opc(ALU_opc), .ImmSrc(ImmSrc), .retire(retire)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ctl_t q_exp[$];
    bit   q_mr[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic bit known(input logic [6:0] o);
        return o == O_R || o == O_I || o == O_LW || o == O_SW || o == O_B ||
               o == O_JAL || o == O_JALR || o == O_LUI;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.pcw = PCWrite; c.adr = AdrSrc; c.mw = MemWrite; c.irw = IRWrite;
        c.rw = RegWrite; c.rs = ResultSrc; c.a = ALUSrcA; c.b = ALUSrcB;
        c.aop = ALU_opc; c.imm = ImmSrc; c.ret = retire;
`ifdef ILLEGAL_TRAP_EN
        c.ill = illegal;
`else
        c.ill = 1'b0;
`endif
        return c;
    endfunction

    function automatic void push(input ctl_t c, input bit mr);
        q_exp.push_back(c);
        q_mr.push_back(mr);
    endfunction

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Write-back cycle shared by R, I, JAL and JALR
    function automatic void push_wb();
        ctl_t c = '0;
        c.rs = 2'b00; c.rw = 1'b1; c.ret = 1'b1;
        push(c, rnd());
    endfunction

    // Builds the expected per-cycle trace of one instruction.
    function automatic void build(input logic [6:0] o, input logic [2:0] f3,
                                  input logic z, input logic n, input int fw, input int mw);
        ctl_t c;
        bit   tk;
        q_exp.delete();
        q_mr.delete();
        // fetch: waits, then the completing cycle
        for (int i = 0; i <= fw; i++) begin
            c = '0; c.a = 2'b00; c.b = 2'b10; c.rs = 2'b10;
            c.irw = (i == fw); c.pcw = (i == fw);
            push(c, i == fw);
        end
        // decode
        c = '0; c.a = 2'b01; c.b = 2'b01;
        c.imm = (o == O_JAL) ? 3'b011 : 3'b010;
        c.ret = !known(o) && !TRAP;
        push(c, rnd());
        case (o)
            O_R:  begin c = '0; c.a = 2'b10; c.b = 2'b00; c.aop = 2'b10; push(c, rnd()); push_wb(); end
            O_I:  begin c = '0; c.a = 2'b10; c.b = 2'b01; c.aop = 2'b11; push(c, rnd()); push_wb(); end
            O_LW: begin
                c = '0; c.a = 2'b10; c.b = 2'b01; c.imm = 3'b000; push(c, rnd());
                for (int i = 0; i <= mw; i++) begin c = '0; c.adr = 1'b1; push(c, i == mw); end
                c = '0; c.rs = 2'b01; c.rw = 1'b1; c.ret = 1'b1; push(c, rnd());
            end
            O_SW: begin
                c = '0; c.a = 2'b10; c.b = 2'b01; c.imm = 3'b001; push(c, rnd());
                for (int i = 0; i <= mw; i++) begin
                    c = '0; c.adr = 1'b1; c.mw = 1'b1; c.ret = (i == mw); push(c, i == mw);
                end
            end
            O_B: begin
                case (f3)
                    3'b000:  tk = z;
                    3'b001:  tk = !z;
                    3'b100:  tk = n;
                    3'b101:  tk = !n;
                    default: tk = 1'b0;
                endcase
                c = '0; c.a = 2'b10; c.b = 2'b00; c.aop = 2'b01; c.rs = 2'b00;
                c.ret = 1'b1; c.pcw = tk; push(c, rnd());
            end
            O_JAL: begin
                c = '0; c.rs = 2'b00; c.pcw = 1'b1; c.a = 2'b01; c.b = 2'b10; push(c, rnd());
                push_wb();
            end
            O_JALR: begin
                c = '0; c.a = 2'b10; c.b = 2'b01; c.imm = 3'b000; c.rs = 2'b10; c.pcw = 1'b1;
                push(c, rnd());
                c = '0; c.a = 2'b01; c.b = 2'b10; push(c, rnd());
                push_wb();
            end
            O_LUI: begin
                c = '0; c.imm = 3'b100; c.rs = 2'b11; c.rw = 1'b1; c.ret = 1'b1; push(c, rnd());
            end
            default: begin
                if (TRAP) begin
                    // HALT for a few cycles, then a reset cycle to leave it
                    for (int i = 0; i < 4; i++) begin c = '0; c.ill = 1'b1; push(c, rnd()); end
                end
            end
        endcase
    endfunction

    // Plays one instruction. abort_at (trace index) asserts rst in that cycle
    // and ends the instruction; negative or out-of-range means no abort.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input logic n, input int fw, input int mw, input int abort_in,
                             output int lat, output logic last_pcw);
        ctl_t got, exp;
        int   abort_at = abort_in;
        build(o, f3, z, n, fw, mw);
        if (TRAP && !known(o) && (abort_at < 0 || abort_at >= q_exp.size()))
            abort_at = q_exp.size() - 1;
        opc = o; func3 = f3; zero = z; neg = n;
        lat = 0;
        last_pcw = 1'b0;
        for (int i = 0; i < q_exp.size(); i++) begin
            rst = (i == abort_at);
            mem_ready = q_mr[i];
            @(negedge clk);
            got = sample();
            exp = q_exp[i];
            if (rst) begin
                check("strobes_in_rst", 32'({got.pcw, got.mw, got.irw, got.rw, got.ret}), 32'd0);
            end else begin
                check("ctl", 32'(got), 32'(exp));
                if (got.ret && lat == 0) lat = i + 1;
            end
            last_pcw = got.pcw;
            @(posedge clk);
            #1;
            cyc++;
            if (rst) break;
        end
        rst = 1'b0;
    endtask

    initial begin
        int   lat;
        logic pcw;
        logic [6:0] o;
        logic [6:0] ops[9];
        ops = '{O_R, O_I, O_LW, O_SW, O_B, O_JAL, O_JALR, O_LUI, 7'h00};

        rst = 1'b1; opc = O_R; func3 = 3'b000; zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        // reset held 2 cycles: strobes must be low
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_strobes", 32'({PCWrite, MemWrite, IRWrite, RegWrite, retire}), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // Directed: latencies and branch decisions against literal values
        run_instr(O_R,    3'b000, 0, 0, 0, 0, -1, lat, pcw); check("lat_R", lat, 4);
        run_instr(O_LW,   3'b010, 0, 0, 0, 3, -1, lat, pcw); check("lat_LW_wait3", lat, 8);
        run_instr(O_LW,   3'b010, 0, 0, 0, 0, -1, lat, pcw); check("lat_LW", lat, 5);
        run_instr(O_I,    3'b000, 0, 0, 0, 0, -1, lat, pcw); check("lat_I", lat, 4);
        run_instr(O_SW,   3'b010, 0, 0, 0, 0, -1, lat, pcw); check("lat_SW", lat, 4);
        run_instr(O_JAL,  3'b000, 0, 0, 0, 0, -1, lat, pcw); check("lat_JAL", lat, 4);
        run_instr(O_JALR, 3'b000, 0, 0, 0, 0, -1, lat, pcw); check("lat_JALR", lat, 5);
        run_instr(O_LUI,  3'b000, 0, 0, 0, 0, -1, lat, pcw); check("lat_LUI", lat, 3);
        run_instr(O_R,    3'b000, 0, 0, 2, 0, -1, lat, pcw); check("lat_R_fetchwait2", lat, 6);
        run_instr(O_B,    3'b000, 1, 0, 0, 0, -1, lat, pcw); check("beq_z1", 32'(pcw), 1);
        check("lat_B", lat, 3);
        run_instr(O_B,    3'b001, 1, 0, 0, 0, -1, lat, pcw); check("bne_z1", 32'(pcw), 0);
        run_instr(O_B,    3'b100, 0, 1, 0, 0, -1, lat, pcw); check("blt_n1", 32'(pcw), 1);
        run_instr(O_B,    3'b101, 0, 1, 0, 0, -1, lat, pcw); check("bge_n1", 32'(pcw), 0);
        run_instr(O_B,    3'b010, 1, 1, 0, 0, -1, lat, pcw); check("b_f3_010", 32'(pcw), 0);
        // SW aborted by rst during a MEM_WR wait cycle (trace index 3)
        run_instr(O_SW,   3'b010, 0, 0, 0, 2, 3, lat, pcw);  check("sw_abort_no_retire", lat, 0);
        run_instr(O_R,    3'b000, 0, 0, 0, 0, -1, lat, pcw); check("lat_R_after_abort", lat, 4);
        // Unknown opcode
        run_instr(7'h7f,  3'b000, 0, 0, 0, 0, -1, lat, pcw);
        check("lat_unknown", lat, TRAP ? 0 : 2);

        // Random instruction stream
        for (int k = 0; k < 300; k++) begin
            o = ops[$urandom_range(0, 8)];
            if (o == 7'h00) begin
                do o = 7'($urandom); while (known(o));
            end
            run_instr(o, 3'($urandom), rnd(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : -1, lat, pcw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
